dmi_jtag_tap: RTL
=================

# dmi_jtag_tap

Oversampled JTAG Test Access Port and Debug Transport Module, upstream of the DMI debug module. It samples TCK/TMS/TDI/TRST in the system clock domain and runs the IEEE 1149.1 TAP state machine. It implements IDCODE, DTMCS, DMI and BYPASS, and turns DMI Update-DR scans into single-cycle-clock DMI register requests: 7-bit address, 32-bit data, read/write. It captures the 32-bit read response for the next scan.

## Interface
- abits, 7: DMI address width; reported in DTMCS.abits.
- irlen, 5: instruction register length.
- idcode, 32'h10e31913: value captured by IDCODE.

- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_trst  in  1  JTAG TRST, async pin, active-low; synchronized internally.
- i_tck  in  1  JTAG clock pin, async; oversampled.
- i_tms  in  1  JTAG mode select pin, async.
- i_tdi  in  1  JTAG data in pin, async.
- o_tdo  out  1  JTAG data out.
- o_dmi_req_valid  out  1  DMI request valid.
- i_dmi_req_ready  in  1  DMI request accepted when high with valid.
- o_dmi_req_write  out  1  1 = write, 0 = read.
- o_dmi_req_addr  out  abits  DMI register index.
- o_dmi_req_data  out  32  write data.
- i_dmi_resp_valid  in  1  one-cycle response strobe.
- i_dmi_resp_data  in  32  read data; valid with i_dmi_resp_valid.
- o_dmi_hardreset  out  1  one-cycle pulse on DTMCS.dmihardreset write.

## Operation
- Synchronizers: 2-flop synchronizer on each of tck, tms, tdi and trst.
  - tck_rise = sync_tck & ~tck_prev.
  - tck_fall = ~sync_tck & tck_prev.
- TAP FSM: 16 standard states; advances only on tck_rise using synchronized tms. Transitions follow IEEE 1149.1.
  - Five tck_rise with tms=1 reach Test-Logic-Reset (TLR) from any state.
- IR codes:
  - IDCODE = 0x01
  - DTMCS = 0x10
  - DMI = 0x11
  - BYPASS = 0x1F; also any unlisted code behaves as BYPASS.
- IR behaviour:
  - Capture-IR loads 5'b00001.
  - Shift-IR shifts right; tdi enters MSB.
  - Update-IR copies the shift register to IR.
  - TLR forces IR = IDCODE.
- DR shift register: 41 bits (abits+34); the active length depends on IR.
  - IDCODE: 32 bits.
  - DTMCS: 32 bits.
  - DMI: abits+34 bits.
  - BYPASS: 1 bit.
  - In Shift-DR, on tck_rise: sr = {tdi, sr[len-1:1]}.
- Capture-DR:
  - IDCODE: loads idcode.
  - DTMCS: loads {14'h0, 1'b0, 1'b0, 1'b0, idle=3'd1, dmistat[1:0], abits[5:0], version=4'h1}.
  - DMI: loads {last_addr, resp_data, dmistat}. dmistat is forced to 3 if a transaction is still pending.
  - BYPASS: loads 0.
- Update-DR, DTMCS:
  - bit16 (dmireset) clears dmistat.
  - bit17 (dmihardreset) clears dmistat and the pending flag, and pulses o_dmi_hardreset for one cycle.
- Update-DR, DMI with op = sr[1:0]:
  - op=1 (read) or op=2 (write), with dmistat==0 and no pending transaction:
    - latch addr = sr[abits+33:34] and data = sr[33:2];
    - assert o_dmi_req_valid;
    - set pending.
  - If pending is already set: no request is issued; dmistat := 3 (sticky).
  - If dmistat != 0: the request is ignored.
  - op=0 or 3: no request.
- DMI handshake:
  - o_dmi_req_valid holds with stable addr/data/write until i_dmi_req_ready; it drops the cycle after acceptance.
  - pending clears on i_dmi_resp_valid. resp_data latches i_dmi_resp_data for reads only; writes leave it unchanged.
  - i_dmi_resp_valid while not pending is ignored.
- TDO:
  - On tck_fall in Shift-IR/Shift-DR, o_tdo := sr[0] (IR sr[0] in Shift-IR). This keeps TDO stable through the next TCK rise.
  - In all other states o_tdo := 0 on tck_fall.
- TRST: synchronized trst low forces TLR and IR = IDCODE. It does not abort a pending DMI transaction.
- i_rst:
  - All state → reset: TAP in TLR, IR = IDCODE, shift registers = 0, dmistat = 0, pending = 0, resp_data = 0, last_addr = 0.
  - All outputs are 0.

## Timing
- Pin-to-effect latency: 3 i_clk cycles (2 sync + edge detect). i_clk must be ≥ 4× TCK and TCK high/low each ≥ 2 i_clk.
- Update-DR is entered on a tck_rise. o_dmi_req_valid rises the following i_clk cycle.
- o_dmi_hardreset: exactly 1 cycle, registered, 1 cycle after the Update-DR edge.
- Simultaneous events:
  - Update-DR DMI on the same cycle as i_dmi_resp_valid: the response is processed first (pending cleared), so the new request is accepted.
  - i_rst on the same cycle as anything: reset wins.

## Test plan
- Reset, then 32 Shift-DR clocks in IDCODE with tdi=0 → TDO stream LSB-first equals 0x10E31913.
- IR=0x1F, shift pattern 1,0,1,1 → TDO lags TDI by exactly one TCK: 0,1,0,1.
- IR=0x10, capture/shift DTMCS → 0x00001071. Write with bit17=1 → o_dmi_hardreset 1-cycle pulse; next capture → 0x00001071.
- IR=0x11 write: addr 0x10, data 0x00000001, op 2 → one request: write=1, addr=0x10, data=1. With ready held 2 cycles late, valid stays high 3 cycles. Then a read of 0x11 with resp 0xDEADBEEF; the next scan captures {0x11, 0xDEADBEEF, 0}.
- Withhold i_dmi_resp_valid and issue a second DMI op → no new request. Next capture dmistat=3; later ops are ignored until DTMCS dmireset=1, after which a read proceeds normally.
- Mid-shift reset:
  - Assert i_trst low during Shift-DR of a DMI scan with pending=1 → TAP in TLR, IR=IDCODE, response still latched on i_dmi_resp_valid.
  - Assert i_rst → all outputs 0 the next cycle.

Source files
------------

// File: rtl/dmi_jtag_tap.sv
// rtl/dmi_jtag_tap.sv - oversampled JTAG TAP and debug transport feeding DMI requests
module dmi_jtag_tap #(
  parameter int          abits  = 7,
  parameter int          irlen  = 5,
  parameter logic [31:0] idcode = 32'h10e31913
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_trst,
  input  logic             i_tck,
  input  logic             i_tms,
  input  logic             i_tdi,
  output logic             o_tdo,
  output logic             o_dmi_req_valid,
  input  logic             i_dmi_req_ready,
  output logic             o_dmi_req_write,
  output logic [abits-1:0] o_dmi_req_addr,
  output logic [31:0]      o_dmi_req_data,
  input  logic             i_dmi_resp_valid,
  input  logic [31:0]      i_dmi_resp_data,
  output logic             o_dmi_hardreset
);

  localparam int DRW = abits + 34;

  localparam logic [irlen-1:0] IR_IDCODE = irlen'(5'h01);
  localparam logic [irlen-1:0] IR_DTMCS  = irlen'(5'h10);
  localparam logic [irlen-1:0] IR_DMI    = irlen'(5'h11);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI
  } dr_sel_t;

  // IEEE 1149.1 next-state function
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:     return tms ? TLR    : RTI;
      RTI:     return tms ? SEL_DR : RTI;
      SEL_DR:  return tms ? SEL_IR : CAP_DR;
      CAP_DR:  return tms ? EX1_DR : SH_DR;
      SH_DR:   return tms ? EX1_DR : SH_DR;
      EX1_DR:  return tms ? UPD_DR : PAU_DR;
      PAU_DR:  return tms ? EX2_DR : PAU_DR;
      EX2_DR:  return tms ? UPD_DR : SH_DR;
      UPD_DR:  return tms ? SEL_DR : RTI;
      SEL_IR:  return tms ? TLR    : CAP_IR;
      CAP_IR:  return tms ? EX1_IR : SH_IR;
      SH_IR:   return tms ? EX1_IR : SH_IR;
      EX1_IR:  return tms ? UPD_IR : PAU_IR;
      PAU_IR:  return tms ? EX2_IR : PAU_IR;
      EX2_IR:  return tms ? UPD_IR : SH_IR;
      UPD_IR:  return tms ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  logic tck_meta, tck_s, tck_prev;
  logic tms_meta, tms_s;
  logic tdi_meta, tdi_s;
  logic trst_meta, trst_s;
  logic tck_rise, tck_fall;

  tap_state_t tap_state;
  tap_state_t tap_nxt;

  logic [irlen-1:0] ir;
  logic [irlen-1:0] ir_sr;
  dr_sel_t          dr_sel;

  logic [DRW-1:0]   dr_sr;
  logic [1:0]       dmistat;
  logic             pending;
  logic             pending_eff;
  logic [31:0]      resp_data;
  logic [abits-1:0] last_addr;
  logic [1:0]       dmi_op;

  // Two-flop synchronizers on every JTAG pin plus TCK history for edge detect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tck_meta  <= 1'b0;
      tck_s     <= 1'b0;
      tck_prev  <= 1'b0;
      tms_meta  <= 1'b0;
      tms_s     <= 1'b0;
      tdi_meta  <= 1'b0;
      tdi_s     <= 1'b0;
      trst_meta <= 1'b1;
      trst_s    <= 1'b1;
    end else begin
      tck_meta  <= i_tck;
      tck_s     <= tck_meta;
      tck_prev  <= tck_s;
      tms_meta  <= i_tms;
      tms_s     <= tms_meta;
      tdi_meta  <= i_tdi;
      tdi_s     <= tdi_meta;
      trst_meta <= i_trst;
      trst_s    <= trst_meta;
    end
  end

  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;
  assign tap_nxt  = tap_next(tap_state, tms_s);

  // An in-flight response retires before a same-cycle Update-DR looks at pending
  assign pending_eff = pending & ~i_dmi_resp_valid;
  assign dmi_op      = dr_sr[1:0];

  // Decode which data register the current instruction selects
  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir == IR_IDCODE)     dr_sel = DR_IDCODE;
    else if (ir == IR_DTMCS) dr_sel = DR_DTMCS;
    else if (ir == IR_DMI)   dr_sel = DR_DMI;
  end

  // TAP controller: steps on synchronized TCK rise, TRST forces Test-Logic-Reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tap_state <= TLR;
    end else if (!trst_s) begin
      tap_state <= TLR;
    end else if (tck_rise) begin
      tap_state <= tap_nxt;
    end
  end

  // Instruction register: capture, shift, and commit on entry to Update-IR
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ir    <= IR_IDCODE;
      ir_sr <= '0;
    end else if (!trst_s || tap_state == TLR) begin
      ir <= IR_IDCODE;
    end else if (tck_rise) begin
      if (tap_state == CAP_IR) begin
        ir_sr <= irlen'(1);
      end else if (tap_state == SH_IR) begin
        ir_sr <= {tdi_s, ir_sr[irlen-1:1]};
      end
      if (tap_nxt == UPD_IR) begin
        ir <= ir_sr;
      end
    end
  end

  // Data registers, DTMCS control and the DMI request/response bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dr_sr           <= '0;
      dmistat         <= 2'd0;
      pending         <= 1'b0;
      resp_data       <= 32'h0;
      last_addr       <= '0;
      o_dmi_req_valid <= 1'b0;
      o_dmi_req_write <= 1'b0;
      o_dmi_req_addr  <= '0;
      o_dmi_req_data  <= 32'h0;
      o_dmi_hardreset <= 1'b0;
    end else begin
      o_dmi_hardreset <= 1'b0;

      if (o_dmi_req_valid && i_dmi_req_ready) begin
        o_dmi_req_valid <= 1'b0;
      end

      if (pending && i_dmi_resp_valid) begin
        pending <= 1'b0;
        if (!o_dmi_req_write) begin
          resp_data <= i_dmi_resp_data;
        end
      end

      if (tck_rise && trst_s) begin
        if (tap_state == CAP_DR) begin
          case (dr_sel)
            DR_IDCODE: dr_sr <= DRW'(idcode);
            DR_DTMCS:  dr_sr <= DRW'({14'h0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat, 6'(abits), 4'h1});
            DR_DMI:    dr_sr <= {last_addr, resp_data, (pending ? 2'd3 : dmistat)};
            default:   dr_sr <= '0;
          endcase
        end else if (tap_state == SH_DR) begin
          case (dr_sel)
            DR_IDCODE,
            DR_DTMCS:  dr_sr[31:0] <= {tdi_s, dr_sr[31:1]};
            DR_DMI:    dr_sr <= {tdi_s, dr_sr[DRW-1:1]};
            default:   dr_sr[0] <= tdi_s;
          endcase
        end

        if (tap_nxt == UPD_DR) begin
          if (dr_sel == DR_DTMCS) begin
            if (dr_sr[17]) begin
              dmistat         <= 2'd0;
              pending         <= 1'b0;
              o_dmi_hardreset <= 1'b1;
            end else if (dr_sr[16]) begin
              dmistat <= 2'd0;
            end
          end else if (dr_sel == DR_DMI && (dmi_op == 2'd1 || dmi_op == 2'd2)) begin
            if (dmistat != 2'd0) begin
              dmistat <= dmistat;
            end else if (pending_eff) begin
              dmistat <= 2'd3;
            end else begin
              last_addr       <= dr_sr[DRW-1:34];
              o_dmi_req_addr  <= dr_sr[DRW-1:34];
              o_dmi_req_data  <= dr_sr[33:2];
              o_dmi_req_write <= (dmi_op == 2'd2);
              o_dmi_req_valid <= 1'b1;
              pending         <= 1'b1;
            end
          end
        end
      end
    end
  end

  // TDO changes on TCK fall so it is stable across the following rise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tdo <= 1'b0;
    end else if (tck_fall) begin
      if (tap_state == SH_IR) begin
        o_tdo <= ir_sr[0];
      end else if (tap_state == SH_DR) begin
        o_tdo <= dr_sr[0];
      end else begin
        o_tdo <= 1'b0;
      end
    end
  end

endmodule
